// File: rtl/inv_cipher_pkg.sv
// Shared widths, FSM encoding and GF(2^8) helpers for the AES-128 inverse cipher.
// Byte 0 of a block occupies bits [127:120]; bytes run column-major.
package inv_cipher_pkg;

    localparam int BLK_S = 128;
    localparam int KEY_S = 128;
    localparam int NK    = 4;
    localparam int NR    = 10;

    localparam logic [NK-1:0] LAST_KEY = NK'(NR);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ADDKEY,
        ROUND,
        FINAL
    } state_e;

    // Listed in natural order 00..ff, so entry x sits at packed index 255-x (= ~x).
    localparam logic [255:0][7:0] INV_SBOX = {
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box: one byte in, one byte out.
module inv_sbox
    import inv_cipher_pkg::*;
(
    input  logic [7:0] in_byte,
    output logic [7:0] out_byte
);

    always_comb begin
        out_byte = INV_SBOX[~in_byte];
    end

endmodule

// File: rtl/inv_cipher.sv
// Iterative AES-128 inverse cipher, one round per clock; round keys are read
// from an external synchronous key SRAM in reverse order (10 down to 0).
module inv_cipher
    import inv_cipher_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [BLK_S-1:0] ciphertext,
    input  logic [KEY_S-1:0] key,
    output logic [NK-1:0]    round_no,
    output logic             r_e,
    output logic [BLK_S-1:0] plaintext,
    output logic             en_o
);

    state_e           state_q, state_d;
    logic [NK-1:0]    cnt_q, cnt_d;
    logic [BLK_S-1:0] st_q, st_d;
    logic [BLK_S-1:0] plaintext_q, plaintext_d;
    logic             en_o_q, en_o_d;
    logic [BLK_S-1:0] isr, isb;

    function automatic logic [BLK_S-1:0] inv_shift_rows(input logic [BLK_S-1:0] s);
        logic [BLK_S-1:0] r;
        r = '0;
        for (int unsigned row = 0; row < 4; row++) begin
            for (int unsigned col = 0; col < 4; col++) begin
                r[BLK_S-1-8*(row+4*col) -: 8] = s[BLK_S-1-8*(row+4*((col+4-row)%4)) -: 8];
            end
        end
        return r;
    endfunction

    // Output byte k of a column = 14*a[k] ^ 11*a[k+1] ^ 13*a[k+2] ^ 9*a[k+3] (indices mod 4).
    function automatic logic [BLK_S-1:0] inv_mix_columns(input logic [BLK_S-1:0] s);
        logic [BLK_S-1:0] r;
        logic [7:0] a[4], x2[4], x4[4], x8[4];
        logic [7:0] m9[4], m11[4], m13[4], m14[4];
        r = '0;
        for (int unsigned col = 0; col < 4; col++) begin
            for (int unsigned k = 0; k < 4; k++) begin
                a[k]   = s[BLK_S-1-8*(4*col+k) -: 8];
                x2[k]  = xtime(a[k]);
                x4[k]  = xtime(x2[k]);
                x8[k]  = xtime(x4[k]);
                m9[k]  = x8[k] ^ a[k];
                m11[k] = x8[k] ^ x2[k] ^ a[k];
                m13[k] = x8[k] ^ x4[k] ^ a[k];
                m14[k] = x8[k] ^ x4[k] ^ x2[k];
            end
            for (int unsigned k = 0; k < 4; k++) begin
                r[BLK_S-1-8*(4*col+k) -: 8] = m14[k] ^ m11[(k+1)%4] ^ m13[(k+2)%4] ^ m9[(k+3)%4];
            end
        end
        return r;
    endfunction

    always_comb begin
        isr = inv_shift_rows(st_q);
    end

    for (genvar i = 0; i < 16; i++) begin : g_sbox
        inv_sbox u_inv_sbox (
            .in_byte  (isr[BLK_S-1-8*i -: 8]),
            .out_byte (isb[BLK_S-1-8*i -: 8])
        );
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            st_q        <= '0;
            plaintext_q <= '0;
            en_o_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            st_q        <= st_d;
            plaintext_q <= plaintext_d;
            en_o_q      <= en_o_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        st_d        = st_q;
        plaintext_d = plaintext_q;
        en_o_d      = 1'b0;
        case (state_q)
            IDLE: begin
                if (en) begin
                    st_d    = ciphertext;
                    cnt_d   = LAST_KEY;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                cnt_d   = cnt_q - 1'b1;
                state_d = ADDKEY;
            end
            ADDKEY: begin
                st_d    = st_q ^ key;
                cnt_d   = cnt_q - 1'b1;
                state_d = ROUND;
            end
            ROUND: begin
                st_d = inv_mix_columns(isb ^ key);
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    state_d = FINAL;
                end
            end
            FINAL: begin
                plaintext_d = isb ^ key;
                en_o_d      = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        r_e       = (state_q == LOAD) || (state_q == ADDKEY) || (state_q == ROUND);
        round_no  = cnt_q;
        plaintext = plaintext_q;
        en_o      = en_o_q;
    end

endmodule
